spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front-end that sits between an external SPI master and the single-port RAM command port.
//  - Deserialises MOSI frames into 10-bit commands: {opcode[1:0], payload[7:0]}. Presents them as rx_data, qualified by rx_valid.
//  - For read-data commands, captures the returned byte (tx_data/tx_valid) and serialises it MSB-first on MISO.
//  - SPI is synchronous to clk (mode 0: master drives MOSI/ss_n so they are stable at each rising clk edge).
// PARAMETERS
//  DATA_W     8     payload width; rx_data width is DATA_W+2, tx_data width is DATA_W
//  MISO_IDLE  1'b0  value driven on miso when not shifting out read data
// PORTS
//  clk       in   1         system clock; also the SPI bit clock
//  rst_n     in   1         asynchronous, active-low reset
//  ss_n      in   1         slave select, active-low; high aborts/ends a frame
//  mosi      in   1         serial data in, MSB first
//  miso      out  1         serial data out, MSB first
//  rx_data   out  DATA_W+2  assembled command {opcode, payload}
//  rx_valid  out  1         one-cycle strobe: rx_data holds a complete command
//  tx_data   in   DATA_W    read byte returned by the RAM
//  tx_valid  in   1         qualifies tx_data; sampled only in READ_DATA after rx_valid
// BEHAVIOUR
//  Reset: miso=MISO_IDLE, rx_data=0, rx_valid=0, state=IDLE, bit_cnt=0, rd_addr_ok=0.
//  Opcodes: 00 write address, 01 write data, 10 read address, 11 read data.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//  IDLE -> CHK_CMD on the first edge ss_n is sampled low; this start cycle carries no data.
//  CHK_CMD samples mosi as opcode[1]:
//   - 0 -> WRITE
//   - 1 and rd_addr_ok=0 -> READ_ADD
//   - 1 and rd_addr_ok=1 -> READ_DATA
//  All frames: DATA_W+2 bits total including the bit taken in CHK_CMD; shift register fills MSB-first.
//  rx_valid: registered, high for exactly 1 cycle, in the cycle after the last bit is sampled.
//   - rx_data updates in that same cycle and holds until the next completed frame.
//   - Latency: ss_n low at edge 0 -> rx_valid high at edge DATA_W+3.
//  The opcode in rx_data is passed through as received; state choice does not alter it.
//  WRITE: after the frame, stay in WRITE until ss_n high -> IDLE. Extra mosi bits are ignored.
//  READ_ADD: frame complete sets rd_addr_ok=1; then wait for ss_n high -> IDLE.
//  READ_DATA sequence:
//   - After rx_valid, wait for tx_valid.
//   - On the tx_valid edge, latch tx_data.
//   - From the next cycle, drive miso = tx_data[DATA_W-1] down to [0], one bit per cycle for DATA_W cycles.
//   - Then drive MISO_IDLE and clear rd_addr_ok.
//   - tx_valid seen before rx_valid, or after the byte is latched, is ignored.
//  ss_n high in any state -> IDLE on the next edge.
//   - Partial frame: no rx_valid; bit_cnt cleared; rx_data unchanged; rd_addr_ok unchanged.
//   - miso returns to MISO_IDLE immediately (registered).
//  ss_n low re-sampled in the same cycle IDLE is entered starts a new frame normally.
//  Reset mid-frame: all state to reset values; no rx_valid.
// CONFIGURATION
//  SPI_FRAME_ERR_EN defined:
//   - Adds output frame_err (1 bit, reset 0), sticky.
//   - Set when ss_n rises before rx_valid of the current frame, or during a READ_DATA shift-out.
//   - Cleared only by rst_n.
//  SPI_FRAME_ERR_EN undefined: no frame_err port; aborts are silent.
// STRUCTURE
//  Package spi_ram_pkg holds:
//   - state enum
//   - opcode localparams OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA
//   - default DATA_W
//  Sub-module spi_shift_unit: SIPO for rx plus PISO for tx, with bit counter, load/shift enables and done flag.
//  The top level keeps the FSM and rd_addr_ok.
// TESTING
//  1. Write-address frame 10'h0_A5 -> rx_data=10'h0A5, rx_valid high exactly 1 cycle at edge 11 after ss_n low.
//  2. Write-data frame 10'h1_3C, then ss_n high -> rx_data=10'h13C, 1 rx_valid; FSM back in IDLE.
//  3. Read-address frame 10'h2_10 -> rx_data=10'h210, rd_addr_ok=1.
//     Then read-data frame 10'h3_00, tx_valid with tx_data=8'hC3 one cycle after rx_valid
//     -> miso 1,1,0,0,0,0,1,1 on the next 8 cycles; rd_addr_ok=0.
//  4. Abort: ss_n high after 5 bits -> no rx_valid, rx_data unchanged; frame_err=1 when SPI_FRAME_ERR_EN.
//  5. Read-data frame with tx_valid delayed 4 cycles -> miso stays MISO_IDLE until shifting starts;
//     stray tx_valid pulsed before rx_valid is ignored.
//  6. rst_n low mid shift-out -> miso=MISO_IDLE, rx_valid=0, rd_addr_ok=0; next frame decoded as READ_ADD.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI front-end of the single-port RAM.
// Opcodes select the RAM command; states are used by the spi_slave_if FSM.
package spi_ram_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Sub-phases of READ_DATA once the command frame has been received.
    typedef enum logic [1:0] {
        RD_WAIT,
        RD_SHIFT,
        RD_DONE
    } rd_phase_t;

endpackage

// File: rtl/spi_shift_unit.sv
// Shared bit counter with a SIPO command receiver and a PISO read-byte transmitter.
// Priority: clr > load_en > shift_en > sample_en.
module spi_shift_unit #(
    parameter int   DATA_W    = 8,
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              sample_en,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic              mosi,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_last,
    output logic              tx_done,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid
);

    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam logic [CNT_W-1:0] RX_LAST_CNT = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] TX_LAST_CNT = CNT_W'(DATA_W);

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W:0]   rx_sr;
    logic [DATA_W-2:0] tx_sr;

    assign rx_last = sample_en && (bit_cnt == RX_LAST_CNT);
    assign tx_done = shift_en && (bit_cnt == TX_LAST_CNT);

    // NOTE: all state here is updated with <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            miso     <= MISO_IDLE;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (clr) begin
                bit_cnt <= '0;
                miso    <= MISO_IDLE;
            end else if (load_en) begin
                miso    <= tx_data[DATA_W-1];
                tx_sr   <= tx_data[DATA_W-2:0];
                bit_cnt <= CNT_W'(1);
            end else if (shift_en) begin
                if (tx_done) begin
                    miso    <= MISO_IDLE;
                    bit_cnt <= '0;
                end else begin
                    miso    <= tx_sr[DATA_W-2];
                    tx_sr   <= tx_sr << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (sample_en) begin
                if (rx_last) begin
                    rx_data  <= {rx_sr, mosi};
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    rx_sr   <= {rx_sr[DATA_W-1:0], mosi};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end for the single-port RAM: command FSM and read-address tracking.
// Optional sticky abort flag frame_err is built when SPI_FRAME_ERR_EN is defined.
module spi_slave_if
    import spi_ram_pkg::*;
#(
    parameter int   DATA_W    = DATA_W_DEF,
    parameter logic MISO_IDLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
`ifdef SPI_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    state_t    state;
    rd_phase_t rd_phase;
    logic      frame_done;
    logic      rd_addr_ok;
    logic      sample_en;
    logic      load_en;
    logic      shift_en;
    logic      rx_last;
    logic      tx_done;

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        sample_en = 1'b0;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        if (!ss_n) begin
            sample_en = (state == CHK_CMD) ||
                        ((state inside {WRITE, READ_ADD, READ_DATA}) && !frame_done);
            load_en   = (state == READ_DATA) && frame_done && (rd_phase == RD_WAIT) && tx_valid;
            shift_en  = (state == READ_DATA) && frame_done && (rd_phase == RD_SHIFT);
        end
    end

    spi_shift_unit #(
        .DATA_W    (DATA_W),
        .MISO_IDLE (MISO_IDLE)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ss_n),
        .sample_en (sample_en),
        .load_en   (load_en),
        .shift_en  (shift_en),
        .mosi      (mosi),
        .tx_data   (tx_data),
        .rx_last   (rx_last),
        .tx_done   (tx_done),
        .miso      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_phase   <= RD_WAIT;
            frame_done <= 1'b0;
            rd_addr_ok <= 1'b0;
        end else if (ss_n) begin
            // Abort or normal end of frame; rd_addr_ok deliberately survives.
            state      <= IDLE;
            rd_phase   <= RD_WAIT;
            frame_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state      <= CHK_CMD;
                    frame_done <= 1'b0;
                end
                CHK_CMD: begin
                    if (!mosi)          state <= WRITE;
                    else if (rd_addr_ok) state <= READ_DATA;
                    else                state <= READ_ADD;
                end
                WRITE: begin
                    if (rx_last) frame_done <= 1'b1;
                end
                READ_ADD: begin
                    if (rx_last) begin
                        frame_done <= 1'b1;
                        rd_addr_ok <= 1'b1;
                    end
                end
                READ_DATA: begin
                    if (rx_last) begin
                        frame_done <= 1'b1;
                        rd_phase   <= RD_WAIT;
                    end else if (load_en) begin
                        rd_phase <= RD_SHIFT;
                    end else if (tx_done) begin
                        rd_phase   <= RD_DONE;
                        rd_addr_ok <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (ss_n && (state != IDLE) &&
                     (!frame_done || ((state == READ_DATA) && (rd_phase == RD_SHIFT)))) begin
            frame_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write/read frames, aborts, delayed tx_valid, mid-shift reset.
// Also checks frame_err when built with SPI_FRAME_ERR_EN.
module tb_spi_slave_if;
    import spi_ram_pkg::*;

    localparam int DW = DATA_W_DEF;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          ss_n     = 1'b1;
    logic          mosi     = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          miso;
    logic          rx_valid;
    logic [DW+1:0] rx_data;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err;
`endif

    int        n_assert = 0;
    int        n_fail   = 0;
    int        rv_count = 0;
    int        rv_mark  = 0;
    logic [7:0] exp_byte;

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(DW), .MISO_IDLE(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
`ifdef SPI_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always @(negedge clk) if (rx_valid === 1'b1) rv_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        ss_n = 1'b0;
        step();
    endtask

    task automatic shift_bits(input logic [9:0] cmd, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mosi = cmd[i];
            step();
        end
    endtask

    task automatic send_frame(input logic [9:0] cmd);
        start_frame();
        shift_bits(cmd, 9, 0);
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        mosi = 1'b0;
        step();
    endtask

    initial begin
        // Reset
        repeat (3) step();
        check("rst_miso", miso, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_rd_addr_ok", dut.rd_addr_ok, 0);
`ifdef SPI_FRAME_ERR_EN
        check("rst_frame_err", frame_err, 0);
`endif
        rst_n = 1'b1;

        // 1: write-address frame, rx_valid one cycle
        rv_mark = rv_count;
        send_frame({OP_WR_ADDR, 8'hA5});
        check("t1_rx_valid_hi", rx_valid, 1);
        check("t1_rx_data", rx_data, 10'h0A5);
        check("t1_state", 32'(dut.state), 32'(WRITE));
        step();
        check("t1_rx_valid_lo", rx_valid, 0);
        check("t1_rv_pulses", rv_count - rv_mark, 1);
        end_frame();
        check("t1_idle", 32'(dut.state), 32'(IDLE));

        // 2: write-data frame with trailing bits ignored
        rv_mark = rv_count;
        send_frame({OP_WR_DATA, 8'h3C});
        mosi = 1'b1; step();
        mosi = 1'b0; step();
        mosi = 1'b1; step();
        end_frame();
        check("t2_rx_data", rx_data, 10'h13C);
        check("t2_rv_pulses", rv_count - rv_mark, 1);
        check("t2_idle", 32'(dut.state), 32'(IDLE));

        // 3: read address then read data with tx one cycle after rx_valid
        send_frame({OP_RD_ADDR, 8'h10});
        check("t3_ra_rx_data", rx_data, 10'h210);
        check("t3_rd_addr_ok", dut.rd_addr_ok, 1);
        check("t3_ra_state", 32'(dut.state), 32'(READ_ADD));
        end_frame();
        send_frame({OP_RD_DATA, 8'h00});
        check("t3_rd_rx_valid", rx_valid, 1);
        check("t3_rd_rx_data", rx_data, 10'h300);
        check("t3_rd_state", 32'(dut.state), 32'(READ_DATA));
        step();
        check("t3_miso_wait", miso, 0);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        step();
        tx_valid = 1'b0;
        exp_byte = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            check("t3_miso_bit", miso, exp_byte[i]);
            step();
        end
        check("t3_miso_idle", miso, 0);
        check("t3_rd_addr_clr", dut.rd_addr_ok, 0);
`ifdef SPI_FRAME_ERR_EN
        check("t3_frame_err", frame_err, 0);
`endif
        end_frame();

        // 4: abort after 5 bits
        rv_mark = rv_count;
        start_frame();
        shift_bits({OP_WR_DATA, 8'h55}, 9, 5);
        end_frame();
        check("t4_rv_pulses", rv_count - rv_mark, 0);
        check("t4_rx_data", rx_data, 10'h300);
        check("t4_idle", 32'(dut.state), 32'(IDLE));
        check("t4_bit_cnt", 32'(dut.u_shift.bit_cnt), 0);
`ifdef SPI_FRAME_ERR_EN
        check("t4_frame_err", frame_err, 1);
`endif

        // 5: stray tx_valid during frame, real tx_valid delayed 4 cycles
        send_frame({OP_RD_ADDR, 8'h44});
        end_frame();
        check("t5_rd_addr_ok", dut.rd_addr_ok, 1);
        rv_mark = rv_count;
        start_frame();
        shift_bits({OP_RD_DATA, 8'h5A}, 9, 5);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        shift_bits({OP_RD_DATA, 8'h5A}, 4, 4);
        tx_valid = 1'b0;
        tx_data  = 8'h96;
        shift_bits({OP_RD_DATA, 8'h5A}, 3, 0);
        check("t5_rx_valid", rx_valid, 1);
        check("t5_rx_data", rx_data, 10'h35A);
        check("t5_miso_wait", miso, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_miso_wait", miso, 0);
        end
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        exp_byte = 8'h96;
        for (int i = 7; i >= 0; i--) begin
            check("t5_miso_bit", miso, exp_byte[i]);
            step();
        end
        check("t5_miso_idle", miso, 0);
        check("t5_rv_pulses", rv_count - rv_mark, 1);
        end_frame();

        // 6: reset in the middle of shift-out
        send_frame({OP_RD_ADDR, 8'h01});
        end_frame();
        send_frame({OP_RD_DATA, 8'h00});
        step();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        step();
        tx_valid = 1'b0;
        step();
        step();
        check("t6_miso_shift", miso, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_miso", miso, 0);
        check("t6_rst_rx_valid", rx_valid, 0);
        check("t6_rst_rd_addr_ok", dut.rd_addr_ok, 0);
        check("t6_rst_rx_data", rx_data, 0);
        check("t6_rst_state", 32'(dut.state), 32'(IDLE));
        ss_n = 1'b1;
        #2;
        rst_n = 1'b1;
        step();
        step();
        start_frame();
        shift_bits({OP_RD_DATA, 8'h77}, 9, 9);
        check("t6_state_rd_add", 32'(dut.state), 32'(READ_ADD));
        shift_bits({OP_RD_DATA, 8'h77}, 8, 0);
        check("t6_rx_data", rx_data, 10'h377);
        check("t6_rd_addr_ok", dut.rd_addr_ok, 1);
        end_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
